fi_div_arb: RTL and testbench

- Shared sequential Q(WS-DP).DP fixed-point divider for the audio effector. NREQ effect channels contend for it through a round-robin arbiter.
- Block contains the arbiter, the operand latch, a one-bit-per-cycle restoring divide FSM and sign/saturation fix-up.
- Sits between the per-channel effect stages (echo gain normalisation, AGC) and replaces one combinational divider per channel.

---
 rtl/fi_div_arb.sv | 183 ++++++++++++++++++
 tb/tb_fi_div_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fi_div_arb.sv
// Shared signed fixed-point divider with a round-robin front end.
// Restoring divide, one quotient bit per clock, then saturation and sign fix-up.
module fi_div_arb #(
  parameter int WS   = 16,
  parameter int DP   = 8,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WS-1:0]   num,
  input  logic [NREQ*WS-1:0]   den,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [WS-1:0]        quo,
  output logic                 dz,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshake: a channel holds req with stable operands until its 1-cycle gnt;
  // its result is valid on quo/dz only in the single cycle done[channel] is high.

  localparam int DW = WS + DP;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [WS-1:0] MAXP = {1'b0, {(WS-1){1'b1}}};
  localparam logic [WS-1:0] MINN = {1'b1, {(WS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WS-1:0]     quo_q, quo_d;
  logic              dz_q, dz_d;
  logic              sign_q, sign_d;
  logic              dzp_q, dzp_d;
  logic              nneg_q, nneg_d;
  logic [WS-1:0]     rem_q, rem_d;
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [WS-1:0]     dmag_q, dmag_d;

  logic [PW-1:0]     win;
  logic              found;
  logic [WS-1:0]     num_sel, den_sel;
  logic              start;
  logic [WS:0]       trial;
  logic [WS-1:0]     sat_mag;

  // Reduced magnitude: the most negative code clips to the largest positive one.
  function automatic logic [WS-1:0] rabs(input logic [WS-1:0] x);
    if (x == MINN)       return MAXP;
    else if (x[WS-1])    return -x;
    else                 return x;
  endfunction

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign num_sel = num[win*WS +: WS];
  assign den_sel = den[win*WS +: WS];
  assign trial   = {rem_q, dvd_q[DW-1]};
  assign sat_mag = (dvd_q > {{DP{1'b0}}, MAXP}) ? MAXP : dvd_q[WS-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    done_d  = '0;
    quo_d   = quo_q;
    dz_d    = dz_q;
    sign_d  = sign_q;
    dzp_d   = dzp_q;
    nneg_d  = nneg_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dmag_d  = dmag_q;
    start   = 1'b0;

    case (state_q)
      S_IDLE: start = |req;
      S_DIV: begin
        if (trial >= {1'b0, dmag_q}) begin
          rem_d = WS'(trial - {1'b0, dmag_q});
          dvd_d = {dvd_q[DW-2:0], 1'b1};
        end else begin
          rem_d = trial[WS-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (dzp_q) begin
          quo_d = nneg_q ? -MAXP : MAXP;
          dz_d  = 1'b1;
        end else begin
          quo_d = (sign_q && sat_mag != '0) ? -sat_mag : sat_mag;
          dz_d  = 1'b0;
        end
        done_d  = NREQ'(1) << owner_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        // Arbitrate again right away so back-to-back requests see no bubble.
        start   = |req;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      owner_d = win;
      ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      gnt_d   = NREQ'(1) << win;
      sign_d  = num_sel[WS-1] ^ den_sel[WS-1];
      nneg_d  = num_sel[WS-1];
      dmag_d  = rabs(den_sel);
      dvd_d   = {rabs(num_sel), {DP{1'b0}}};
      rem_d   = '0;
      cnt_d   = '0;
      dzp_d   = (den_sel == '0);
      state_d = (den_sel == '0) ? S_FIX : S_DIV;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
      sign_q  <= 1'b0;
      dzp_q   <= 1'b0;
      nneg_q  <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dmag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
      sign_q  <= sign_d;
      dzp_q   <= dzp_d;
      nneg_q  <= nneg_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dmag_q  <= dmag_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign quo       = quo_q;
  assign dz        = dz_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fi_div_arb.sv
// Directed bench for fi_div_arb: driver issues requests and queues expected
// grants/results; a negedge monitor pops and compares on every gnt/done.
module tb_fi_div_arb;
  localparam int WS = 16;
  localparam int DP = 8;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*WS-1:0]  num, den;
  logic [NREQ-1:0]     gnt, done;
  logic [WS-1:0]       quo;
  logic                dz, busy;
  logic [1:0]          dbg_state;

  fi_div_arb #(.WS(WS), .DP(DP), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .num(num), .den(den),
    .gnt(gnt), .done(done), .quo(quo), .dz(dz), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {latency[28:21], done one-hot[20:17], dz[16], quo[15:0]}
  logic [28:0] exp_q[$];
  logic [3:0]  gnt_exp_q[$];
  int checks = 0;
  int errors = 0;
  int last_gnt_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        if (gnt_exp_q.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'h0);
        else chk("gnt", 32'(gnt), 32'(gnt_exp_q.pop_front()));
        last_gnt_cyc = cyc;
      end
      if (done != '0) begin
        chk("gnt_done_excl", 32'(gnt), 32'h0);
        if (exp_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
        else begin
          logic [28:0] e;
          e = exp_q.pop_front();
          chk("done", 32'(done), 32'(e[20:17]));
          chk("quo", 32'(quo), 32'(e[15:0]));
          chk("dz", 32'(dz), 32'(e[16]));
          chk("latency", 32'(cyc - last_gnt_cyc), 32'(e[28:21]));
        end
      end
    end
  end

  // driver tasks
  task automatic set_ops(input int ch, input logic [15:0] n, input logic [15:0] d);
    num[ch*WS +: WS] = n;
    den[ch*WS +: WS] = d;
  endtask

  task automatic expect_op(input int ch, input logic [15:0] q, input logic z, input int lat);
    exp_q.push_back({8'(lat), 4'(1 << ch), z, q});
    gnt_exp_q.push_back(4'(1 << ch));
  endtask

  task automatic run(input logic [3:0] mask, input int ngnt);
    int seen = 0;
    int t = 0;
    req = mask;
    while (seen < ngnt && t < 2000) begin
      @(negedge clk);
      t++;
      if (gnt != '0) seen++;
    end
    req = '0;
    if (seen < ngnt) chk("gnt_timeout", 32'(seen), 32'(ngnt));
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("done_timeout", 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic single(input int ch, input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] q, input logic z);
    set_ops(ch, n, d);
    expect_op(ch, q, z, z ? 1 : WS + DP + 1);
    run(4'(1 << ch), 1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req = '0;
    num = '0;
    den = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_quo", 32'(quo), 32'h0);
    chk("rst_dz", 32'(dz), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // basic, sign/truncation, saturation, divide by zero
    single(0, 16'h0300, 16'h0200, 16'h0180, 1'b0);
    chk("busy_after_out", 32'(busy), 32'h0);
    chk("quo_hold", 32'(quo), 32'h0180);
    single(0, 16'hFF00, 16'h0300, 16'hFFAB, 1'b0);
    single(1, 16'h0100, 16'hFD00, 16'hFFAB, 1'b0);
    single(2, 16'h7F00, 16'h0080, 16'h7FFF, 1'b0);
    single(3, 16'h8000, 16'h0040, 16'h8001, 1'b0);
    single(0, 16'h0080, 16'h0300, 16'h002A, 1'b0);
    single(1, 16'hFD00, 16'hFE00, 16'h0180, 1'b0);
    single(0, 16'h0100, 16'h0000, 16'h7FFF, 1'b1);
    single(2, 16'hFFFB, 16'h0000, 16'h8001, 1'b1);
    chk("dz_hold", 32'(dz), 32'h1);
    single(1, 16'h0300, 16'h0200, 16'h0180, 1'b0);
    chk("dz_cleared", 32'(dz), 32'h0);

    // round robin with all requests held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ops(0, 16'h0300, 16'h0200);
    set_ops(1, 16'hFF00, 16'h0300);
    set_ops(2, 16'h0100, 16'h0000);
    set_ops(3, 16'h0080, 16'h0300);
    expect_op(0, 16'h0180, 1'b0, 25);
    expect_op(1, 16'hFFAB, 1'b0, 25);
    expect_op(2, 16'h7FFF, 1'b1, 1);
    expect_op(3, 16'h002A, 1'b0, 25);
    expect_op(0, 16'h0180, 1'b0, 25);
    run(4'b1111, 5);
    expect_op(2, 16'h7FFF, 1'b1, 1);
    run(4'b0100, 1);
    expect_op(3, 16'h002A, 1'b0, 25);
    run(4'b1010, 1);

    // reset in the middle of a divide
    set_ops(0, 16'h0300, 16'h0200);
    gnt_exp_q.push_back(4'b0001);
    req = 4'b0001;
    t = 0;
    while (gnt == '0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    req = '0;
    if (gnt == '0) chk("abort_gnt_timeout", 32'(gnt), 32'h1);
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_quo", 32'(quo), 32'h0);
    chk("abort_dz", 32'(dz), 32'h0);
    chk("abort_state", 32'(dbg_state), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    set_ops(1, 16'hFF00, 16'h0300);
    expect_op(1, 16'hFFAB, 1'b0, 25);
    run(4'b0110, 1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("gnt_q_empty", 32'(gnt_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
